// File: rtl/ioctl_upload_responder.sv
// Answers HPS uploads of one ioctl file index by pausing the CPU and streaming core RAM
// back one byte per ioctl_rd, holding ioctl_wait high while each byte is fetched.
//   state   | meaning
//   S_IDLE  | not uploading; ioctl_din holds the last delivered byte
//   S_PAUSE | pause_req raised, waiting for the CPU to halt
//   S_READY | CPU halted, accepting ioctl_rd
//   S_FETCH | RAM read in flight (or finished and held until pause_ack)
module ioctl_upload_responder #(
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         MEM_AW       = 11,
  parameter int         MEM_SIZE     = 2048,
  parameter int         RD_LAT       = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_READY, S_FETCH} state_t;

  state_t            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              pause_q, pause_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              busy_q, busy_d;
  logic              pend_q, pend_d;
  logic [24:0]       pend_addr_q, pend_addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              oor_q, oor_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [7:0]        buf_q, buf_d;

  logic              active;
  logic              go;
  logic [24:0]       go_addr;
  logic              have_byte;
  logic [7:0]        byte_val;
  logic              abort_now;

  assign active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      din_q       <= 8'h00;
      wait_q      <= 1'b0;
      pause_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      cnt_q       <= 3'd0;
      oor_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      buf_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      pause_q     <= pause_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
      oor_q       <= oor_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      buf_q       <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    wait_d      = wait_q;
    pause_d     = pause_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    oor_d       = oor_q;
    done_d      = done_q;
    abort_d     = abort_q;
    buf_d       = buf_q;
    go          = 1'b0;
    go_addr     = '0;
    have_byte   = 1'b0;
    byte_val    = buf_q;
    abort_now   = abort_q || !active;

    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (active) begin
          state_d = S_PAUSE;
          pause_d = 1'b1;
          wait_d  = 1'b1;
        end
      end

      S_PAUSE: begin
        if (!active) begin
          state_d = S_IDLE;
          pause_d = 1'b0;
          wait_d  = 1'b0;
          pend_d  = 1'b0;
        end else begin
          // Only the first early request is kept; it is served the moment the CPU halts.
          if (ioctl_rd && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = ioctl_addr;
          end
          if (pause_ack) begin
            if (pend_q || ioctl_rd) begin
              go      = 1'b1;
              go_addr = pend_q ? pend_addr_q : ioctl_addr;
            end else begin
              state_d = S_READY;
              wait_d  = 1'b0;
            end
          end
        end
      end

      S_READY: begin
        if (!active) begin
          state_d = S_IDLE;
          pause_d = 1'b0;
          wait_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (!pause_ack) begin
          wait_d = 1'b1;
          if (ioctl_rd && !wait_q && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = ioctl_addr;
          end
        end else if (pend_q) begin
          go      = 1'b1;
          go_addr = pend_addr_q;
        end else if (ioctl_rd && !wait_q) begin
          go      = 1'b1;
          go_addr = ioctl_addr;
        end else begin
          wait_d = 1'b0;
        end
      end

      S_FETCH: begin
        if (!active) abort_d = 1'b1;
        if (done_q) begin
          have_byte = 1'b1;
          byte_val  = buf_q;
        end else if (cnt_q == 3'd0) begin
          have_byte = 1'b1;
          byte_val  = oor_q ? 8'hFF : mem_dout;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
        if (have_byte) begin
          if (abort_now) begin
            state_d = S_IDLE;
            pause_d = 1'b0;
            wait_d  = 1'b0;
            done_d  = 1'b0;
            abort_d = 1'b0;
            pend_d  = 1'b0;
          end else if (pause_ack) begin
            state_d = S_READY;
            din_d   = byte_val;
            wait_d  = 1'b0;
            done_d  = 1'b0;
          end else begin
            // CPU resumed mid-fetch: park the byte until it halts again.
            buf_d  = byte_val;
            done_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (go) begin
      state_d = S_FETCH;
      wait_d  = 1'b1;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      abort_d = 1'b0;
      if (go_addr < 25'(MEM_SIZE)) begin
        mem_rd_d   = 1'b1;
        mem_addr_d = go_addr[MEM_AW-1:0];
        cnt_d      = 3'(RD_LAT);
        oor_d      = 1'b0;
      end else begin
        cnt_d = 3'd0;
        oor_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = pause_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Directed and randomized bench for ioctl_upload_responder with a latency-accurate RAM model.
module tb_ioctl_upload_responder;

  localparam int MEM_AW   = 11;
  localparam int MEM_SIZE = 2048;
  localparam int RD_LAT   = 2;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_req;
  logic              pause_ack;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_dout;
  logic              busy;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_responder #(
    .UPLOAD_INDEX(8'd4), .MEM_AW(MEM_AW), .MEM_SIZE(MEM_SIZE), .RD_LAT(RD_LAT)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_req(pause_req),
    .pause_ack(pause_ack), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .busy(busy)
  );

  // RAM: data valid RD_LAT cycles after the strobe, filler value otherwise.
  logic [7:0] ram  [MEM_SIZE];
  logic [7:0] pipe [RD_LAT];
  always @(posedge clk_sys) begin
    pipe[0] <= mem_rd ? ram[mem_addr] : 8'hE7;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[RD_LAT-1];

  int rd_cnt = 0;
  always @(posedge clk_sys) if (mem_rd) rd_cnt <= rd_cnt + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_din = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [24:0] a);
    if (a < 25'(MEM_SIZE)) return ram[a[MEM_AW-1:0]];
    return 8'hFF;
  endfunction

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // Called with the request (or the ack that releases a latched one) applied in cycle T.
  task automatic fetch_and_check(input logic [24:0] a, input bit viol, input string tag);
    int rc0;
    bit inr;
    rc0 = rd_cnt;
    inr = (a < 25'(MEM_SIZE));
    tick;
    ioctl_rd = 1'b0;
    chk({tag, " wait_t1"}, 32'(ioctl_wait), 32'd1);
    chk({tag, " mem_rd"}, 32'(mem_rd), 32'(inr));
    if (inr) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(a[MEM_AW-1:0]));
    if (viol) begin
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'($urandom);
    end
    if (inr) begin
      repeat (RD_LAT) begin
        tick;
        ioctl_rd = 1'b0;
        chk({tag, " wait_mid"}, 32'(ioctl_wait), 32'd1);
      end
    end
    tick;
    ioctl_rd = 1'b0;
    chk({tag, " din"}, 32'(ioctl_din), 32'(model_byte(a)));
    chk({tag, " wait_done"}, 32'(ioctl_wait), 32'd0);
    chk({tag, " rd_count"}, 32'(rd_cnt - rc0), 32'(inr));
    last_din = model_byte(a);
  endtask

  task automatic do_read(input logic [24:0] a, input bit viol, input string tag);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    fetch_and_check(a, viol, tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " din"}, 32'(ioctl_din), 32'd0);
    chk({tag, " wait"}, 32'(ioctl_wait), 32'd0);
    chk({tag, " pause_req"}, 32'(pause_req), 32'd0);
    chk({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rc0;
    logic [24:0] a;

    for (int i = 0; i < MEM_SIZE; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = '0; pause_ack = 1'b0;
    tick; tick;
    chk_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(i);
      tick;
      ioctl_rd = 1'b0;
      tick;
    end
    chk("idle rd_count", 32'(rd_cnt), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);

    // Happy path: ack three cycles after pause_req
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    tick;
    chk("pause pause_req", 32'(pause_req), 32'd1);
    chk("pause wait", 32'(ioctl_wait), 32'd1);
    chk("pause busy", 32'(busy), 32'd1);
    tick;
    chk("pause hold wait", 32'(ioctl_wait), 32'd1);
    tick;
    pause_ack = 1'b1;
    tick;
    chk("ready wait", 32'(ioctl_wait), 32'd0);
    chk("ready pause_req", 32'(pause_req), 32'd1);
    for (int i = 0; i < 4; i++) do_read(25'(i), 1'b0, "happy");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) a = 25'($urandom);
      else a = 25'($urandom_range(0, MEM_SIZE - 1));
      repeat ($urandom_range(0, 2)) tick;
      do_read(a, ($urandom_range(0, 3) == 0), "rand");
    end

    do_read(25'd2047, 1'b0, "edge_in");
    do_read(25'd2048, 1'b0, "oor_2048");
    do_read(25'h1000000, 1'b0, "oor_hi");
    do_read(25'h1FFFFFF, 1'b1, "oor_max");

    // CPU resumes while idle in READY
    pause_ack = 1'b0;
    tick;
    chk("ackdrop wait", 32'(ioctl_wait), 32'd1);
    chk("ackdrop pause_req", 32'(pause_req), 32'd1);
    pause_ack = 1'b1;
    tick;
    chk("ackback wait", 32'(ioctl_wait), 32'd0);

    // CPU resumes mid-fetch: byte withheld until ack returns
    rc0 = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd9;
    tick;
    ioctl_rd = 1'b0; pause_ack = 1'b0;
    repeat (RD_LAT + 3) begin
      tick;
      chk("hold wait", 32'(ioctl_wait), 32'd1);
    end
    chk("hold din", 32'(ioctl_din), 32'(last_din));
    pause_ack = 1'b1;
    tick;
    chk("hold release din", 32'(ioctl_din), 32'(ram[9]));
    chk("hold release wait", 32'(ioctl_wait), 32'd0);
    chk("hold rd_count", 32'(rd_cnt - rc0), 32'd1);
    last_din = ram[9];

    // Early request during PAUSE
    ioctl_upload = 1'b0;
    tick;
    chk("leave pause_req", 32'(pause_req), 32'd0);
    chk("leave busy", 32'(busy), 32'd0);
    chk("leave din", 32'(ioctl_din), 32'(last_din));
    pause_ack = 1'b0; ioctl_upload = 1'b1;
    tick;
    chk("early pause_req", 32'(pause_req), 32'd1);
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick;
    ioctl_rd = 1'b0;
    chk("early wait", 32'(ioctl_wait), 32'd1);
    chk("early no mem_rd", 32'(mem_rd), 32'd0);
    tick;
    rc0 = rd_cnt;
    pause_ack = 1'b1;
    fetch_and_check(25'd5, 1'b0, "early");
    repeat (3) tick;
    chk("early single read", 32'(rd_cnt - rc0), 32'd1);

    // Upload aborted while a read is in flight
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    tick;
    ioctl_rd = 1'b0;
    chk("abort mem_rd", 32'(mem_rd), 32'd1);
    tick;
    ioctl_upload = 1'b0;
    repeat (RD_LAT - 1) begin
      tick;
      chk("abort drain pause_req", 32'(pause_req), 32'd1);
      chk("abort drain busy", 32'(busy), 32'd1);
    end
    tick;
    chk("abort pause_req", 32'(pause_req), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort wait", 32'(ioctl_wait), 32'd0);
    chk("abort din", 32'(ioctl_din), 32'(last_din));
    pause_ack = 1'b0;

    // Foreign index is ignored
    rc0 = rd_cnt;
    ioctl_index = 8'd0; ioctl_upload = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(i);
      tick;
      ioctl_rd = 1'b0;
      chk("wrongidx pause_req", 32'(pause_req), 32'd0);
      chk("wrongidx busy", 32'(busy), 32'd0);
      chk("wrongidx wait", 32'(ioctl_wait), 32'd0);
    end
    chk("wrongidx rd_count", 32'(rd_cnt - rc0), 32'd0);

    // Reset in the middle of a fetch
    ioctl_index = 8'd4;
    tick;
    pause_ack = 1'b1;
    tick;
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    tick;
    ioctl_rd = 1'b0;
    chk("midreset mem_rd", 32'(mem_rd), 32'd1);
    reset_n = 1'b0;
    tick;
    chk_all_zero("midreset");
    reset_n = 1'b1; ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick;
    chk("post reset busy", 32'(busy), 32'd0);
    chk("post reset din", 32'(ioctl_din), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
